// File: rtl/pulse_train_generator.sv
// Purpose: turns a one-cycle start strobe into N level pulses (H high, L low) on out_sig.
// Latency: out_sig rises on the cycle after the launching edge; done follows the last high cycle.
// Backpressure: none; start is ignored while busy and stop aborts immediately.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   start       launch request, only honoured while idle
//   stop        synchronous abort, wins over start and over counting
//   high_len    H, cycles high per pulse (0 behaves as 1)
//   low_len     L, cycles low between pulses (0 behaves as 1)
//   num_pulses  N, pulses per train (0 = empty train, done only)
//   out_sig     registered pulse train
//   busy        train in progress
//   done        one-cycle strobe on normal completion
//   pulse_cnt   complete pulses emitted in the current/last train

module pulse_train_generator #(
    parameter int LEN_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             out_sig,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Remaining cycles in the current phase minus one; zero marks the last cycle.
    logic [LEN_W-1:0] phase_q, phase_d;

    // Train parameters captured at launch so mid-train input changes are ignored.
    logic [LEN_W-1:0] high_q, high_d;
    logic [LEN_W-1:0] low_q, low_d;
    logic [NUM_W-1:0] num_q, num_d;

    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             out_sig_q, out_sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] high_eff;
    logic [LEN_W-1:0] low_eff;
    logic [NUM_W-1:0] pulse_cnt_inc;

    // Zero-length phases would make pulses vanish or merge; clamp to one cycle.
    assign high_eff      = (high_len == '0) ? LEN_W'(1) : high_len;
    assign low_eff       = (low_len == '0) ? LEN_W'(1) : low_len;
    assign pulse_cnt_inc = pulse_cnt_q + NUM_W'(1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        high_d      = high_q;
        low_d       = low_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    high_d      = high_eff;
                    low_d       = low_eff;
                    num_d       = num_pulses;
                    pulse_cnt_d = '0;
                    if (num_pulses == '0) begin
                        // Empty train: completes immediately without leaving idle.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        phase_d = high_eff - LEN_W'(1);
                    end
                end
            end

            ST_HIGH: begin
                if (phase_q == '0) begin
                    pulse_cnt_d = pulse_cnt_inc;
                    if (pulse_cnt_inc == num_q) begin
                        // Final pulse: no trailing low phase, idle takes over.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        phase_d = low_q - LEN_W'(1);
                    end
                end else begin
                    phase_d = phase_q - LEN_W'(1);
                end
            end

            ST_LOW: begin
                if (phase_q == '0) begin
                    state_d = ST_HIGH;
                    phase_d = high_q - LEN_W'(1);
                end else begin
                    phase_d = phase_q - LEN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything above; the completed-pulse count is kept.
        if (stop) begin
            state_d     = ST_IDLE;
            done_d      = 1'b0;
            pulse_cnt_d = pulse_cnt_q;
        end

        // Outputs are registered copies of the next-state decode.
        out_sig_d = (state_d == ST_HIGH);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            num_q       <= '0;
            pulse_cnt_q <= '0;
            out_sig_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            high_q      <= high_d;
            low_q       <= low_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            out_sig_q   <= out_sig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_sig   = out_sig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] high_len = 8'd0;
    logic [7:0] low_len = 8'd0;
    logic [7:0] num_pulses = 8'd0;
    logic       out_sig;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    pulse_train_generator #(.LEN_W(8), .NUM_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .stop       (stop),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .out_sig    (out_sig),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a train is a timeline of T = N*H + (N-1)*L cycles indexed
    // by t; pulse k is high for t in [k*P, k*P+H) with P = H+L.
    int m_act = 0;
    int m_t = 0;
    int m_H = 1;
    int m_L = 1;
    int m_N = 0;
    int e_out = 0;
    int e_busy = 0;
    int e_done = 0;
    int e_pc = 0;

    function automatic int pulses_done(input int t, input int h, input int p);
        return (t < h) ? 0 : ((t - h) / p + 1);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_act = 0;
            m_t = 0;
            e_out = 0;
            e_busy = 0;
            e_done = 0;
            e_pc = 0;
        end else begin
            e_done = 0;
            if (stop) begin
                m_act = 0;
            end else if (m_act != 0) begin
                m_t++;
                if (m_t == m_N * m_H + (m_N - 1) * m_L) begin
                    m_act = 0;
                    e_done = 1;
                end
            end else if (start) begin
                m_H = (high_len == 0) ? 1 : int'(high_len);
                m_L = (low_len == 0) ? 1 : int'(low_len);
                m_N = int'(num_pulses);
                e_pc = 0;
                if (m_N == 0) begin
                    e_done = 1;
                end else begin
                    m_act = 1;
                    m_t = 0;
                end
            end
            if (m_act != 0) e_pc = pulses_done(m_t, m_H, m_H + m_L);
            else if (e_done != 0) e_pc = m_N;
            e_out = ((m_act != 0) && ((m_t % (m_H + m_L)) < m_H)) ? 1 : 0;
            e_busy = m_act;
        end
    end

    // Compare process plus activity monitor, sampled on the falling edge.
    int busy_cnt = 0;
    int done_cnt = 0;
    int edge_cnt = 0;
    int cyc = 0;
    logic prev_out = 1'b0;
    bit rec = 1'b0;
    int done_cyc[$];

    always @(negedge clk) begin
        chk("out_sig", int'(out_sig), e_out);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("pulse_cnt", int'(pulse_cnt), e_pc);
        cyc++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (rec) done_cyc.push_back(cyc);
        end
        if (out_sig && !prev_out) edge_cnt++;
        prev_out = out_sig;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon;
        busy_cnt = 0;
        done_cnt = 0;
        edge_cnt = 0;
    endtask

    // Leaves the bench in the cycle right after the launching edge (t = 0).
    task automatic launch;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin : stim
        logic [5:0] seq_out;
        logic [5:0] seq_done;

        // 1: reset held for 4 clocks with start asserted.
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_out", int'(out_sig), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_pc", int'(pulse_cnt), 0);
        end
        tick();
        start = 1'b0;
        rstn = 1'b1;
        repeat (2) tick();

        // 2: H=5 L=5 N=4.
        high_len = 8'd5; low_len = 8'd5; num_pulses = 8'd4;
        clr_mon();
        launch();
        repeat (45) tick();
        chk("t2_busy_cycles", busy_cnt, 35);
        chk("t2_done_cycles", done_cnt, 1);
        chk("t2_edges", edge_cnt, 4);
        chk("t2_pulse_cnt", int'(pulse_cnt), 4);

        // 3: zero lengths behave as 1/1.
        high_len = 8'd0; low_len = 8'd0; num_pulses = 8'd3;
        clr_mon();
        launch();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq_out[5-i] = out_sig;
            seq_done[5-i] = done;
        end
        tick();
        chk("t3_out_seq", int'(seq_out), 6'b101010);
        chk("t3_done_seq", int'(seq_done), 6'b000001);
        chk("t3_edges", edge_cnt, 3);

        // 4: empty train.
        high_len = 8'd5; low_len = 8'd5; num_pulses = 8'd0;
        tick();
        clr_mon();
        launch();
        @(negedge clk);
        chk("t4_done_first", int'(done), 1);
        chk("t4_busy_first", int'(busy), 0);
        @(negedge clk);
        chk("t4_done_second", int'(done), 0);
        repeat (5) tick();
        chk("t4_edges", edge_cnt, 0);
        chk("t4_busy_cycles", busy_cnt, 0);
        chk("t4_done_cycles", done_cnt, 1);

        // 5: stop during the third high phase.
        high_len = 8'd3; low_len = 8'd2; num_pulses = 8'd5;
        tick();
        clr_mon();
        launch();
        repeat (11) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("t5_out", int'(out_sig), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_pc", int'(pulse_cnt), 2);
        repeat (10) tick();
        chk("t5_done_cycles", done_cnt, 0);
        chk("t5_edges", edge_cnt, 3);
        chk("t5_pc_hold", int'(pulse_cnt), 2);

        // stop and start together while idle: no launch.
        clr_mon();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        repeat (4) tick();
        chk("ss_busy_cycles", busy_cnt, 0);
        chk("ss_done_cycles", done_cnt, 0);

        // 6: start held high, H=2 L=2 N=2 -> back-to-back trains every 7 cycles.
        high_len = 8'd2; low_len = 8'd2; num_pulses = 8'd2;
        clr_mon();
        done_cyc.delete();
        rec = 1'b1;
        start = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        repeat (10) tick();
        rec = 1'b0;
        chk("t6_ndone_ge5", (done_cyc.size() >= 5) ? 1 : 0, 1);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("t6_done_gap", done_cyc[i] - done_cyc[i-1], 7);

        // Async reset in the middle of a train.
        high_len = 8'd4; low_len = 8'd4; num_pulses = 8'd3;
        clr_mon();
        launch();
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        chk("ar_out", int'(out_sig), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        chk("ar_pc", int'(pulse_cnt), 0);
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        chk("ar_done_cycles", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
